// File: rtl/adder_nbit.sv
// Registered N-bit unsigned adder with carry-out and a valid qualifier.
// Define ADDER_NBIT_PIPE_EN to split the add into two pipeline stages (2-cycle latency).
module adder_nbit #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N:0]   sum
);

`ifdef ADDER_NBIT_PIPE_EN
  localparam int L = (N + 1) / 2;
  localparam int H = N - L;

  logic [L-1:0] lo_p1_d, lo_p1_q;
  logic         cy_p1_d, cy_p1_q;
  logic [H-1:0] ahi_p1_q, bhi_p1_q;
  logic         vld_p1_q;
  logic [H:0]   hi_p2_d;
  logic [N:0]   sum_p2_d, sum_p2_q;
  logic         vld_p2_q;

  // Stage 1: low half add; upper operand bits travel with the partial sum
  always_comb begin
    {cy_p1_d, lo_p1_d} = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      lo_p1_q  <= '0;
      cy_p1_q  <= 1'b0;
      ahi_p1_q <= '0;
      bhi_p1_q <= '0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        lo_p1_q  <= lo_p1_d;
        cy_p1_q  <= cy_p1_d;
        ahi_p1_q <= a[N-1:L];
        bhi_p1_q <= b[N-1:L];
      end
    end
  end

  // Stage 2: upper half plus the registered low-half carry
  always_comb begin
    hi_p2_d  = {1'b0, ahi_p1_q} + {1'b0, bhi_p1_q} + {{H{1'b0}}, cy_p1_q};
    sum_p2_d = {hi_p2_d, lo_p1_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      sum_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sum_p2_q <= sum_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
`else
  logic [N:0] sum_p1_d, sum_p1_q;
  logic       vld_p1_q;

  // Stage 1: full-width add; sum holds its value on idle cycles
  always_comb begin
    sum_p1_d = {1'b0, a} + {1'b0, b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      sum_p1_q <= '0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        sum_p1_q <= sum_p1_d;
      end
    end
  end

  assign out_valid = vld_p1_q;
  assign sum       = sum_p1_q;
`endif

endmodule

// File: tb/tb_adder_nbit.sv
// Directed and random checks of adder_nbit at N=10, N=2 and N=17.
// Latency follows ADDER_NBIT_PIPE_EN, matching the RTL build.
module tb_adder_nbit;
`ifdef ADDER_NBIT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv10, ov10, iv2, ov2, iv17, ov17;
  logic [9:0]  a10, b10;
  logic [10:0] s10;
  logic [1:0]  a2, b2;
  logic [2:0]  s2;
  logic [16:0] a17, b17;
  logic [17:0] s17;

  adder_nbit #(.N(10)) dut10 (.clk(clk), .rst(rst), .in_valid(iv10), .a(a10), .b(b10),
                              .out_valid(ov10), .sum(s10));
  adder_nbit #(.N(2))  dut2  (.clk(clk), .rst(rst), .in_valid(iv2), .a(a2), .b(b2),
                              .out_valid(ov2), .sum(s2));
  adder_nbit #(.N(17)) dut17 (.clk(clk), .rst(rst), .in_valid(iv17), .a(a17), .b(b17),
                              .out_valid(ov17), .sum(s17));

  typedef struct {
    logic [31:0] s;
    int          c;
  } exp_t;
  exp_t q10[$], q2[$], q17[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Output monitors: each valid output must match the oldest expected entry at its due cycle.
  exp_t e10, e2, e17;
  always @(negedge clk) begin
    if (!rst && ov10) begin
      if (q10.size() == 0) check("n10_spurious_vld", 32'd1, 32'd0);
      else begin
        e10 = q10.pop_front();
        check("n10_sum", 32'(s10), e10.s);
        check("n10_latency", 32'(cyc), 32'(e10.c));
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && ov2) begin
      if (q2.size() == 0) check("n2_spurious_vld", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("n2_sum", 32'(s2), e2.s);
        check("n2_latency", 32'(cyc), 32'(e2.c));
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && ov17) begin
      if (q17.size() == 0) check("n17_spurious_vld", 32'd1, 32'd0);
      else begin
        e17 = q17.pop_front();
        check("n17_sum", 32'(s17), e17.s);
        check("n17_latency", 32'(cyc), 32'(e17.c));
      end
    end
  end

  task automatic send10(input logic [9:0] x, input logic [9:0] y, input logic [31:0] e);
    iv10 = 1'b1;
    a10  = x;
    b10  = y;
    q10.push_back('{e, cyc + LAT});
    @(negedge clk);
  endtask

  task automatic idle10();
    iv10 = 1'b0;
    a10  = 10'($urandom);
    b10  = 10'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    iv10 = 1'b0; a10 = '0; b10 = '0;
    iv2  = 1'b0; a2  = '0; b2  = '0;
    iv17 = 1'b0; a17 = '0; b17 = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_n10_vld", 32'(ov10), 32'd0);
    check("rst_n10_sum", 32'(s10), 32'd0);
    check("rst_n2_vld",  32'(ov2),  32'd0);
    check("rst_n2_sum",  32'(s2),   32'd0);
    check("rst_n17_vld", 32'(ov17), 32'd0);
    check("rst_n17_sum", 32'(s17),  32'd0);
    rst = 1'b0;

    // back-to-back stream
    send10(10'd0,   10'd0,  32'd0);
    send10(10'd1,   10'd99, 32'd100);
    send10(10'd33,  10'd66, 32'd99);
    send10(10'd100, 10'd47, 32'd147);
    // carry-out boundary
    send10(10'd1023, 10'd1023, 32'd2046);
    send10(10'd1023, 10'd1,    32'd1024);
    // single pulse then hold while operands toggle
    send10(10'd5, 10'd7, 32'd12);
    repeat (3) idle10();
    check("hold_sum", 32'(s10), 32'd12);
    check("hold_vld", 32'(ov10), 32'd0);
    idle10();
    check("hold_sum2", 32'(s10), 32'd12);

    // asynchronous reset with a pair in flight
    iv10 = 1'b1;
    a10  = 10'd200;
    b10  = 10'd300;
`ifdef ADDER_NBIT_PIPE_EN
    @(posedge clk);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sum", 32'(s10), 32'd0);
    check("async_rst_vld", 32'(ov10), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_held_sum", 32'(s10), 32'd0);
    check("rst_held_vld", 32'(ov10), 32'd0);
    iv10 = 1'b0;
    rst  = 1'b0;
    send10(10'd3, 10'd4, 32'd7);
    repeat (LAT + 2) idle10();
    check("post_rst_sum", 32'(s10), 32'd7);

    // random traffic on all three widths
    for (int i = 0; i < 300; i++) begin
      iv10 = ($urandom_range(0, 3) != 0);
      iv2  = ($urandom_range(0, 3) != 0);
      iv17 = ($urandom_range(0, 3) != 0);
      a10 = 10'($urandom); b10 = 10'($urandom);
      a2  = 2'($urandom);  b2  = 2'($urandom);
      a17 = 17'($urandom); b17 = 17'($urandom);
      if (i % 50 == 0) begin
        a2 = 2'd3; b2 = 2'd3; a17 = 17'h1FFFF; b17 = 17'h1FFFF;
      end
      if (iv10) q10.push_back('{32'(a10) + 32'(b10), cyc + LAT});
      if (iv2)  q2.push_back('{32'(a2) + 32'(b2), cyc + LAT});
      if (iv17) q17.push_back('{32'(a17) + 32'(b17), cyc + LAT});
      @(negedge clk);
    end
    iv10 = 1'b0; iv2 = 1'b0; iv17 = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    check("drain_n10", 32'(q10.size()), 32'd0);
    check("drain_n2",  32'(q2.size()),  32'd0);
    check("drain_n17", 32'(q17.size()), 32'd0);
    check("idle_vld_n10", 32'(ov10), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adder_nbit.md
ADDER_NBIT -- requirements
Module: adder_nbit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: N, default 10, unsigned operand width in bits; legal range N >= 2.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  qualifies a and b on the current clk edge.
REQ-006 Port: a  input  N  unsigned operand A.
REQ-007 Port: b  input  N  unsigned operand B.
REQ-008 Port: out_valid  output  1  high for one cycle per accepted operand pair.
REQ-009 Port: sum  output  N+1  registered unsigned sum a+b; the MSB is the carry-out.

Function
REQ-010 sum SHALL equal the full unsigned sum a+b, zero-extended to N+1 bits, with no truncation and no wrap; the maximum value is 2^(N+1)-2 when a = b = 2^N-1.
REQ-011 Default latency SHALL be 1 cycle: an operand pair sampled with in_valid=1 on edge k SHALL appear on sum with out_valid=1 after edge k.
REQ-012 Throughput SHALL be one operand pair per cycle. There is no back-pressure, and back-to-back valid inputs SHALL produce back-to-back valid outputs in input order.
REQ-013 When in_valid=0 on an edge, out_valid SHALL be 0 after that edge, and sum SHALL hold its last value.
REQ-014 a and b SHALL be ignored when in_valid=0. X or changing operand values while in_valid=0 SHALL NOT affect sum.
REQ-015 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-016 While rst=1, sum SHALL be 0 and out_valid SHALL be 0, regardless of clk.
REQ-017 Asserting rst while a result is in flight SHALL discard that result; no out_valid pulse SHALL follow the deassertion of rst.
REQ-018 The first edge after rst deasserts SHALL accept inputs normally.

Configuration
REQ-019 Macro ADDER_NBIT_PIPE_EN, when defined, SHALL build a two-stage pipeline:
- Stage 1 adds the low L = ceil(N/2) bits and registers the partial sum, the carry, and the upper operand bits together with a valid bit.
- Stage 2 adds the upper bits plus the registered carry.
REQ-020 With ADDER_NBIT_PIPE_EN defined:
- latency SHALL be 2 cycles;
- throughput SHALL remain one pair per cycle;
- results SHALL be bit-identical to the unpipelined build;
- reset SHALL clear all stage registers and valid bits.
REQ-021 Without ADDER_NBIT_PIPE_EN, the block SHALL be the single-stage, 1-cycle-latency adder described in REQ-011.

Verification (N=10 unless stated)
REQ-022 Drive in_valid=1 with a=0,b=0; then 1,99; then 33,66; then 100,47, back-to-back. Required: out_valid=1 for 4 consecutive cycles with sum = 0, 100, 99, 147 at the configured latency.
REQ-023 Drive a=1023, b=1023 with in_valid=1. Required: sum=2046 (sum[10]=1). Then drive a=1023, b=1. Required: sum=1024.
REQ-024 Drive one valid pair a=5, b=7, then in_valid=0 for 3 cycles while a and b toggle randomly. Required: a single out_valid pulse, and sum holds 12.
REQ-025 Drive a valid pair a=200, b=300 and assert rst asynchronously before its result appears. Required: sum=0 and out_valid=0 immediately. After release, no pulse for the discarded pair appears; the next pair a=3, b=4 yields sum=7.
REQ-026 Run random back-to-back traffic at N=2, N=10 and N=17, each with and without ADDER_NBIT_PIPE_EN. Required: every output matches the reference a+b, in order, at the configured latency.
